// File: rtl/fpu_mem_arbiter.sv
// rtl/fpu_mem_arbiter.sv - round-robin arbiter sharing one MMU read/write port among FPUs (optional watchdog: MEM_ARB_TIMEOUT_EN)
module fpu_mem_arbiter #(
    parameter int NUM_FPUS       = 16,
    parameter int FPU_ID_WIDTH   = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_FPUS-1:0]            fpu_mem_req,
    input  logic [NUM_FPUS-1:0]            fpu_mem_write,
    input  logic [NUM_FPUS*ADDR_WIDTH-1:0] fpu_mem_addr,
    input  logic [NUM_FPUS*DATA_WIDTH-1:0] fpu_mem_write_data,
    output logic [NUM_FPUS-1:0]            fpu_mem_ack,
    output logic [DATA_WIDTH-1:0]          fpu_mem_read_data,
    output logic                           fpu_mem_error,
    output logic [ADDR_WIDTH-1:0]          read_addr,
    output logic                           read_valid,
    input  logic [DATA_WIDTH-1:0]          read_data,
    input  logic                           read_ready,
    output logic [ADDR_WIDTH-1:0]          write_addr,
    output logic [DATA_WIDTH-1:0]          write_data,
    output logic                           write_valid,
    input  logic                           write_ready,
    output logic                           debug_busy,
    output logic [FPU_ID_WIDTH-1:0]        debug_owner,
    output logic [15:0]                    debug_xfer_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                  state;
    logic [FPU_ID_WIDTH-1:0] owner;
    logic [FPU_ID_WIDTH-1:0] last_owner;
    logic                    grant_valid;
    logic [FPU_ID_WIDTH-1:0] grant_idx;
    logic [FPU_ID_WIDTH-1:0] cand;
    logic [NUM_FPUS-1:0]     owner_onehot;

    // First requester scanning upward from the slot after the previous owner.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_FPUS; i++) begin
            cand = FPU_ID_WIDTH'((32'(last_owner) + 32'(i) + 32'd1) % 32'(NUM_FPUS));
            if (!grant_valid && fpu_mem_req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign owner_onehot = NUM_FPUS'(1) << owner;
    assign debug_busy   = (state != IDLE);
    assign debug_owner  = owner;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [15:0] timer;
    logic        timer_hit;

    assign timer_hit = (timer == 16'(TIMEOUT_CYCLES - 1));
`else
    assign fpu_mem_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            owner             <= '0;
            last_owner        <= FPU_ID_WIDTH'(NUM_FPUS - 1);
            fpu_mem_ack       <= '0;
            fpu_mem_read_data <= '0;
            read_addr         <= '0;
            read_valid        <= 1'b0;
            write_addr        <= '0;
            write_data        <= '0;
            write_valid       <= 1'b0;
            debug_xfer_count  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            timer             <= '0;
            fpu_mem_error     <= 1'b0;
`endif
        end else begin
            fpu_mem_ack <= '0;
            case (state)
                IDLE: begin
                    fpu_mem_read_data <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
                    fpu_mem_error     <= 1'b0;
                    timer             <= '0;
`endif
                    if (grant_valid) begin
                        owner <= grant_idx;
                        if (fpu_mem_write[grant_idx]) begin
                            write_addr  <= fpu_mem_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                            write_data  <= fpu_mem_write_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                            write_valid <= 1'b1;
                            state       <= WRITE;
                        end else begin
                            read_addr  <= fpu_mem_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                            read_valid <= 1'b1;
                            state      <= READ;
                        end
                    end
                end
                READ: begin
                    if (read_ready) begin
                        read_valid        <= 1'b0;
                        fpu_mem_read_data <= read_data;
                        fpu_mem_ack       <= owner_onehot;
                        state             <= RESP;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (timer_hit) begin
                        read_valid        <= 1'b0;
                        fpu_mem_read_data <= '0;
                        fpu_mem_error     <= 1'b1;
                        fpu_mem_ack       <= owner_onehot;
                        state             <= RESP;
                    end else begin
                        timer <= timer + 16'd1;
                    end
`endif
                end
                WRITE: begin
                    if (write_ready) begin
                        write_valid       <= 1'b0;
                        fpu_mem_read_data <= '0;
                        fpu_mem_ack       <= owner_onehot;
                        state             <= RESP;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (timer_hit) begin
                        write_valid       <= 1'b0;
                        fpu_mem_read_data <= '0;
                        fpu_mem_error     <= 1'b1;
                        fpu_mem_ack       <= owner_onehot;
                        state             <= RESP;
                    end else begin
                        timer <= timer + 16'd1;
                    end
`endif
                end
                RESP: begin
                    last_owner       <= owner;
                    debug_xfer_count <= debug_xfer_count + 16'd1;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
